// File: rtl/led_scan_capture.sv
// rtl/led_scan_capture.sv - reconstructs the hex value shown on a 4-digit multiplexed 7-segment bus (optional GLITCH_COUNT_EN)
module led_scan_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_err,
    output logic [7:0]  glitch_cnt
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {
        COLLECT,
        PUBLISH
    } state_t;

    state_t       state;
    logic [3:0]   an_s;
    logic [6:0]   seg_s;
    logic [10:0]  prev_s;
    logic [7:0]   stab_cnt;
    logic [7:0]   stab_next;
    logic         captured;
    logic         strobe;
    logic         same;
    logic         capture;
    logic [1:0]   digit;
    logic [3:0]   nibble;
    logic         pat_err;
    logic [3:0]   mask;
    logic [3:0]   mask_next;
    logic [15:0]  shadow;
    logic [15:0]  shadow_next;
    logic [3:0]   shadow_err;
    logic [3:0]   err_next;

    // Inverse of the hex-to-segment table; returns {error, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0000100: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b1100000: decode = 5'h0B;
            7'b0110001: decode = 5'h0C;
            7'b1000010: decode = 5'h0D;
            7'b0110000: decode = 5'h0E;
            7'b0111000: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    // Register the display bus once; prev_s holds the sample before it for the stability compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_s   <= '0;
            seg_s  <= '0;
            prev_s <= '0;
        end else begin
            an_s   <= an;
            seg_s  <= seg;
            prev_s <= {an_s, seg_s};
        end
    end

    // A sample is a strobe only with exactly one anode low; its position selects the digit.
    always_comb begin
        strobe = 1'b1;
        digit  = 2'd0;
        case (an_s)
            4'b1110: digit = 2'd0;
            4'b1101: digit = 2'd1;
            4'b1011: digit = 2'd2;
            4'b0111: digit = 2'd3;
            default: strobe = 1'b0;
        endcase
    end

    assign same             = ({an_s, seg_s} == prev_s);
    assign {pat_err, nibble} = decode(seg_s);

    // Saturating run length of identical strobe samples; capture fires once when it hits the threshold.
    always_comb begin
        stab_next = 8'd0;
        if (strobe) begin
            if (same)
                stab_next = (stab_cnt == 8'hFF) ? 8'hFF : stab_cnt + 8'd1;
            else
                stab_next = 8'd1;
        end
    end

    assign capture = strobe && (stab_next == STABLE) && !captured;

    // Stability counter and the captured flag that blocks repeats until the pattern changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_cnt <= '0;
            captured <= 1'b0;
        end else begin
            stab_cnt <= stab_next;
            if (capture)
                captured <= 1'b1;
            else if (!(strobe && same))
                captured <= 1'b0;
        end
    end

    // Shadow frame as it would look after this edge's capture (latest capture of a digit wins).
    always_comb begin
        mask_next   = mask;
        shadow_next = shadow;
        err_next    = shadow_err;
        if (capture) begin
            mask_next[digit]                 = 1'b1;
            shadow_next[{digit, 2'b00} +: 4] = nibble;
            err_next[digit]                  = pat_err;
        end
    end

    // Frame FSM: publish on the edge that completes the mask; PUBLISH only retires the strobe and
    // keeps accepting captures so a coincident digit lands in the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= COLLECT;
            mask        <= '0;
            shadow      <= '0;
            shadow_err  <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            shadow     <= shadow_next;
            shadow_err <= err_next;
            case (state)
                COLLECT: begin
                    if (mask_next == 4'b1111) begin
                        value       <= shadow_next;
                        digit_err   <= err_next;
                        frame_valid <= 1'b1;
                        mask        <= '0;
                        state       <= PUBLISH;
                    end else begin
                        mask <= mask_next;
                    end
                end
                PUBLISH: begin
                    frame_valid <= 1'b0;
                    mask        <= mask_next;
                    state       <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef GLITCH_COUNT_EN
    logic glitch;
    logic glitch_prev;

    assign glitch = (an_s != 4'b1111) && !strobe;

    // Count entries into the multi-anode condition, saturating at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_prev <= 1'b0;
            glitch_cnt  <= '0;
        end else begin
            glitch_prev <= glitch;
            if (glitch && !glitch_prev && glitch_cnt != 8'hFF)
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_led_scan_capture.sv
// tb/tb_led_scan_capture.sv - scoreboard bench for led_scan_capture
module tb_led_scan_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_err;
    logic [7:0]  glitch_cnt;

    int total = 0;
    int bad   = 0;
    int frames = 0;
    logic fv_prev = 1'b0;
    logic [19:0] exp_q[$];

    led_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg),
        .value(value), .frame_valid(frame_valid),
        .digit_err(digit_err), .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_seg = 7'b0000001;  4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;  4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;  4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;  4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;  4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;  4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;  4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;  default: hex_seg = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    // Scoreboard monitor: every frame_valid pulse pops and checks one expected frame.
    always @(negedge clk) begin
        if (reset && frame_valid) begin
            frames++;
            total++;
            if (fv_prev) begin
                bad++;
                $display("FAIL pulse_width frame_valid high two cycles");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame value=%h err=%b expected none", value, digit_err);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({value, digit_err} !== e) begin
                    bad++;
                    $display("FAIL frame value=%h err=%b expected value=%h err=%b",
                             value, digit_err, e[19:4], e[3:0]);
                end
            end
        end
        fv_prev = frame_valid;
    end

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        show(4'b1111, 7'b1111111, n);
    endtask

    task automatic show_value(input logic [15:0] v, input int hold3);
        for (int d = 0; d < 4; d++)
            show(an_of(d), hex_seg(v[d*4 +: 4]), (d == 3) ? hold3 : 8);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
        blank(4);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        an = 4'b1111;
        seg = 7'b1111111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (value !== 16'h0)      begin bad++; $display("FAIL reset_value got=%h exp=0000", value); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        total++; if (digit_err !== 4'h0)   begin bad++; $display("FAIL reset_err got=%b exp=0000", digit_err); end
        total++; if (glitch_cnt !== 8'h0)  begin bad++; $display("FAIL reset_glitch got=%0d exp=0", glitch_cnt); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        blank(3);
    endtask

    task automatic test_basic;
        exp_q.push_back({16'h4321, 4'b0000});
        show_value(16'h4321, 8);
        wait_drain("basic");
    endtask

    task automatic test_bad_digit;
        exp_q.push_back({16'h4021, 4'b0100});
        show(4'b1110, hex_seg(4'h1), 8);
        show(4'b1101, hex_seg(4'h2), 8);
        show(4'b1011, 7'b1111111, 8);
        show(4'b0111, hex_seg(4'h4), 8);
        wait_drain("bad_digit");
    endtask

    task automatic test_short_strobe;
        int f0;
        f0 = frames;
        show_value(16'h4321, 3);
        blank(6);
        total++;
        if (frames !== f0) begin bad++; $display("FAIL short_strobe frames=%0d expected %0d", frames, f0); end
        exp_q.push_back({16'h4321, 4'b0000});
        show_value(16'h4321, 8);
        wait_drain("short_strobe_retry");
    endtask

    task automatic test_glitch;
        int f0;
        logic [7:0] exp_g;
        f0 = frames;
        show(4'b1100, hex_seg(4'h0), 5);
        blank(3);
        show(4'b1100, hex_seg(4'h0), 5);
        blank(4);
`ifdef GLITCH_COUNT_EN
        exp_g = 8'd2;
`else
        exp_g = 8'd0;
`endif
        total++;
        if (glitch_cnt !== exp_g) begin bad++; $display("FAIL glitch_cnt got=%0d exp=%0d", glitch_cnt, exp_g); end
        total++;
        if (frames !== f0) begin bad++; $display("FAIL glitch_capture frames=%0d expected %0d", frames, f0); end
    endtask

    task automatic test_latest_wins;
        exp_q.push_back({16'h0007, 4'b0000});
        show(4'b1110, hex_seg(4'h5), 8);
        show(4'b1110, hex_seg(4'h7), 8);
        show(4'b1101, hex_seg(4'h0), 8);
        show(4'b1011, hex_seg(4'h0), 8);
        show(4'b0111, hex_seg(4'h0), 8);
        wait_drain("latest_wins");
    endtask

    task automatic test_latency;
        exp_q.push_back({16'hDBA6, 4'b0000});
        show(4'b1110, hex_seg(4'h6), 8);
        show(4'b1101, hex_seg(4'hA), 8);
        show(4'b1011, hex_seg(4'hB), 8);
        an  = 4'b0111;
        seg = hex_seg(4'hD);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL latency_early fv=%b exp=0", frame_valid); end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b1) begin bad++; $display("FAIL latency_edge fv=%b exp=1", frame_valid); end
        @(posedge clk);
        #1;
        show(4'b0111, hex_seg(4'hD), 3);
        wait_drain("latency");
    endtask

    task automatic test_reset_mid;
        int f0;
        show(4'b1110, hex_seg(4'h8), 8);
        show(4'b1101, hex_seg(4'h9), 8);
        reset = 1'b0;
        #2;
        total++; if (value !== 16'h0)      begin bad++; $display("FAIL midreset_value got=%h exp=0000", value); end
        total++; if (digit_err !== 4'h0)   begin bad++; $display("FAIL midreset_err got=%b exp=0000", digit_err); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midreset_fv got=%b exp=0", frame_valid); end
        total++; if (glitch_cnt !== 8'h0)  begin bad++; $display("FAIL midreset_glitch got=%0d exp=0", glitch_cnt); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        blank(3);
        f0 = frames;
        show(4'b1011, hex_seg(4'hC), 8);
        show(4'b0111, hex_seg(4'hE), 8);
        blank(4);
        total++;
        if (frames !== f0) begin bad++; $display("FAIL midreset_partial frames=%0d expected %0d", frames, f0); end
        exp_q.push_back({16'hECF1, 4'b0000});
        show(4'b1110, hex_seg(4'h1), 8);
        show(4'b1101, hex_seg(4'hF), 8);
        wait_drain("midreset_refill");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bad_digit;
        test_short_strobe;
        test_glitch;
        test_latest_wins;
        test_latency;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
